ext_adc_arbiter: RTL

//  Shares one external ADC (AdcStart/AdcDone/AdcValue handshake) between NumReq

---
 rtl/ext_adc_arbiter.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/ext_adc_arbiter.sv
// Round-robin arbiter sharing one external ADC between NumReq requesters.
// Optional conversion timeout enabled by defining EXTADC_ARB_TIMEOUT_EN.
module ext_adc_arbiter #(
  parameter int NumReq    = 4,
  parameter int DataWidth = 16,
  parameter int CntWidth  = 16
) (
  input  logic                 Clk_i,
  input  logic                 Reset_n_i,
  input  logic                 Enable_i,
  input  logic [NumReq-1:0]    ReqStart_i,
  output logic [NumReq-1:0]    ReqDone_o,
  output logic [DataWidth-1:0] ReqValue_o,
  output logic [NumReq-1:0]    Grant_o,
  output logic                 Busy_o,
  output logic                 AdcStart_o,
  input  logic                 AdcDone_i,
  input  logic [DataWidth-1:0] AdcValue_i,
  input  logic [CntWidth-1:0]  TimeoutPreset_i,
  output logic                 TimeoutIRQ_o
);

  localparam int IdxW = $clog2(NumReq);

  typedef enum logic [1:0] {ST_IDLE, ST_CONVERT, ST_RELEASE} state_t;

  state_t                r_state, w_state_nxt;
  logic [IdxW-1:0]       r_last, w_last_nxt;
  logic [IdxW-1:0]       r_gidx, w_gidx_nxt;
  logic [IdxW-1:0]       w_pick, w_scan;
  logic                  w_pick_vld;
  logic                  r_abort, w_abort_nxt, w_abort_now;
  logic [NumReq-1:0]     r_grant, w_grant_nxt;
  logic [NumReq-1:0]     r_done, w_done_nxt;
  logic [DataWidth-1:0]  r_value, w_value_nxt;
  logic                  r_busy, w_busy_nxt;
  logic                  r_adc_start, w_adc_start_nxt;
  logic                  r_irq, w_irq_nxt;
  logic                  w_req_g;
  logic                  w_expired;

`ifdef EXTADC_ARB_TIMEOUT_EN
  logic [CntWidth-1:0]   r_cnt, w_cnt_nxt;

  // Expiry is the edge on which the counter would step from 1 to 0.
  assign w_expired = (r_cnt == CntWidth'(1));
`else
  logic                  w_unused_preset;

  assign w_unused_preset = ^TimeoutPreset_i;
  assign w_expired       = 1'b0;
`endif

  assign w_req_g     = ReqStart_i[r_gidx];
  // An abort is sticky: once the owner drops its start the result is discarded.
  assign w_abort_now = r_abort | ~w_req_g;

  always_comb begin
    w_pick     = '0;
    w_pick_vld = 1'b0;
    w_scan     = '0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      w_scan = IdxW'((32'(r_last) + k + 1) % NumReq);
      if (!w_pick_vld && ReqStart_i[w_scan]) begin
        w_pick_vld = 1'b1;
        w_pick     = w_scan;
      end
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_last_nxt      = r_last;
    w_gidx_nxt      = r_gidx;
    w_abort_nxt     = r_abort;
    w_grant_nxt     = r_grant;
    w_done_nxt      = '0;
    w_value_nxt     = r_value;
    w_busy_nxt      = r_busy;
    w_adc_start_nxt = r_adc_start;
    w_irq_nxt       = 1'b0;
`ifdef EXTADC_ARB_TIMEOUT_EN
    w_cnt_nxt       = r_cnt;
`endif
    case (r_state)
      ST_IDLE: begin
        if (Enable_i && w_pick_vld) begin
          w_state_nxt     = ST_CONVERT;
          w_gidx_nxt      = w_pick;
          w_abort_nxt     = 1'b0;
          w_grant_nxt     = NumReq'(1) << w_pick;
          w_busy_nxt      = 1'b1;
          w_adc_start_nxt = 1'b1;
`ifdef EXTADC_ARB_TIMEOUT_EN
          w_cnt_nxt       = TimeoutPreset_i;
`endif
        end
      end
      ST_CONVERT: begin
        w_abort_nxt = w_abort_now;
`ifdef EXTADC_ARB_TIMEOUT_EN
        if (r_cnt != '0) w_cnt_nxt = r_cnt - CntWidth'(1);
`endif
        if (AdcDone_i) begin
          if (!w_abort_now) begin
            w_value_nxt = AdcValue_i;
            w_done_nxt  = NumReq'(1) << r_gidx;
          end
          w_adc_start_nxt = 1'b0;
          w_state_nxt     = ST_RELEASE;
        end else if (w_expired) begin
          w_irq_nxt = 1'b1;
          if (!w_abort_now) begin
            w_value_nxt = '1;
            w_done_nxt  = NumReq'(1) << r_gidx;
          end
          w_adc_start_nxt = 1'b0;
          w_state_nxt     = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (!w_req_g && !AdcDone_i) begin
          w_last_nxt  = r_gidx;
          w_grant_nxt = '0;
          w_busy_nxt  = 1'b0;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk_i or negedge Reset_n_i) begin
    if (!Reset_n_i) begin
      r_state     <= ST_IDLE;
      r_last      <= IdxW'(NumReq - 1);
      r_gidx      <= '0;
      r_abort     <= 1'b0;
      r_grant     <= '0;
      r_done      <= '0;
      r_value     <= '0;
      r_busy      <= 1'b0;
      r_adc_start <= 1'b0;
      r_irq       <= 1'b0;
`ifdef EXTADC_ARB_TIMEOUT_EN
      r_cnt       <= '0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_last      <= w_last_nxt;
      r_gidx      <= w_gidx_nxt;
      r_abort     <= w_abort_nxt;
      r_grant     <= w_grant_nxt;
      r_done      <= w_done_nxt;
      r_value     <= w_value_nxt;
      r_busy      <= w_busy_nxt;
      r_adc_start <= w_adc_start_nxt;
      r_irq       <= w_irq_nxt;
`ifdef EXTADC_ARB_TIMEOUT_EN
      r_cnt       <= w_cnt_nxt;
`endif
    end
  end

  assign ReqDone_o    = r_done;
  assign ReqValue_o   = r_value;
  assign Grant_o      = r_grant;
  assign Busy_o       = r_busy;
  assign AdcStart_o   = r_adc_start;
  assign TimeoutIRQ_o = r_irq;

endmodule
